// File: rtl/game_controller_if.sv
// Bundles the move request, merge-datapath handshake and status signals of the 2048 game controller.
// The controller uses the master side; the board-side environment and merge datapath use the slave side.
interface game_controller_if;
   logic                  dir_valid;
   logic [3:0]            direction;
   logic [3:0]            mm_direction;
   logic [3:0][3:0][11:0] mm_board_in;
   logic [3:0][3:0][11:0] mm_board_out;
   logic [19:0]           mm_score_update;
   logic                  mm_done;
   logic [3:0][3:0][11:0] board;
   logic [19:0]           score;
   logic                  busy;
   logic                  moved;
   logic                  game_won;
   logic                  game_over;

   modport master (
      input  dir_valid, direction, mm_board_out, mm_score_update, mm_done,
      output mm_direction, mm_board_in, board, score, busy, moved, game_won, game_over
   );

   modport slave (
      output dir_valid, direction, mm_board_out, mm_score_update, mm_done,
      input  mm_direction, mm_board_in, board, score, busy, moved, game_won, game_over
   );
endinterface

// File: rtl/game_controller.sv
// 2048 game sequencer: one request per IDLE visit, waits on mm_done, then commit/spawn/check; busy=1 outside IDLE.
// Optional macro SPAWN_FOUR_EN: spawn 12'h004 instead of 12'h002 when LFSR[7:4] == 0.
module game_controller (
   input  logic              clk,
   input  logic              rst,
   game_controller_if.master gif
);
   typedef enum logic [2:0] {INIT, IDLE, MOVE, COMMIT, SPAWN, CHECK, WON, OVER} state_t;
   typedef logic [3:0][3:0][11:0] board_t;

   state_t      state_q, state_d;
   board_t      board_q, board_d, cap_board_q, cap_board_d;
   logic [19:0] score_q, score_d, cap_score_q, cap_score_d;
   logic [3:0]  dir_q, dir_d, idx_q, idx_d, tries_q, tries_d;
   logic        first_q, first_d, init_left_q, init_left_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [3:0]  cur_idx;
   logic [11:0] new_tile;
   logic [20:0] score_sum;
   logic        has_800, has_empty, has_pair, changed, dir_onehot;

   assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign changed    = (cap_board_q != board_q);
   assign score_sum  = {1'b0, score_q} + {1'b0, cap_score_q};
   assign dir_onehot = gif.direction inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
   // First probe of a spawn uses the live LFSR; later probes walk forward from the last one.
   assign cur_idx    = first_q ? lfsr_q[3:0] : idx_q;

`ifdef SPAWN_FOUR_EN
   assign new_tile = (lfsr_q[7:4] == 4'h0) ? 12'h004 : 12'h002;
`else
   assign new_tile = 12'h002;
`endif

   assign gif.board       = board_q;
   assign gif.score       = score_q;
   assign gif.mm_board_in = board_q;
   assign gif.busy        = (state_q != IDLE);
   assign gif.game_won    = (state_q == WON);
   assign gif.game_over   = (state_q == OVER);

   always_comb begin
      has_800   = 1'b0;
      has_empty = 1'b0;
      has_pair  = 1'b0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (board_q[r][c] == 12'h800) has_800 = 1'b1;
            if (board_q[r][c] == 12'h000) has_empty = 1'b1;
         end
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (board_q[r][c] == board_q[r][c+1]) has_pair = 1'b1;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 4; c++)
            if (board_q[r][c] == board_q[r+1][c]) has_pair = 1'b1;
   end

   always_comb begin
      state_d          = state_q;
      board_d          = board_q;
      score_d          = score_q;
      cap_board_d      = cap_board_q;
      cap_score_d      = cap_score_q;
      dir_d            = dir_q;
      idx_d            = idx_q;
      tries_d          = tries_q;
      first_d          = first_q;
      init_left_d      = init_left_q;
      gif.mm_direction = 4'b0000;
      gif.moved        = 1'b0;
      case (state_q)
         INIT: begin
            board_d     = '0;
            score_d     = '0;
            init_left_d = 1'b1;
            first_d     = 1'b1;
            tries_d     = 4'd0;
            state_d     = SPAWN;
         end
         IDLE: begin
            if (gif.dir_valid && dir_onehot) begin
               dir_d   = gif.direction;
               state_d = MOVE;
            end
         end
         MOVE: begin
            gif.mm_direction = dir_q;
            if (gif.mm_done) begin
               cap_board_d = gif.mm_board_out;
               cap_score_d = gif.mm_score_update;
               state_d     = COMMIT;
            end
         end
         COMMIT: begin
            if (changed) begin
               board_d   = cap_board_q;
               score_d   = score_sum[20] ? 20'hFFFFF : score_sum[19:0];
               gif.moved = 1'b1;
               first_d   = 1'b1;
               tries_d   = 4'd0;
               state_d   = SPAWN;
            end else begin
               state_d = IDLE;
            end
         end
         SPAWN: begin
            first_d = 1'b0;
            if (board_q[cur_idx[3:2]][cur_idx[1:0]] == 12'h000) begin
               board_d[cur_idx[3:2]][cur_idx[1:0]] = new_tile;
               if (init_left_q) begin
                  init_left_d = 1'b0;
                  first_d     = 1'b1;
                  tries_d     = 4'd0;
               end else begin
                  state_d = CHECK;
               end
            end else if (tries_q == 4'hF) begin
               // Full board from the datapath: nothing to place, let CHECK decide.
               init_left_d = 1'b0;
               state_d     = CHECK;
            end else begin
               idx_d   = cur_idx + 4'd1;
               tries_d = tries_q + 4'd1;
            end
         end
         CHECK: begin
            if (has_800)                     state_d = WON;
            else if (!has_empty && !has_pair) state_d = OVER;
            else                             state_d = IDLE;
         end
         WON:     state_d = WON;
         OVER:    state_d = OVER;
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= INIT;
         board_q     <= '0;
         score_q     <= '0;
         cap_board_q <= '0;
         cap_score_q <= '0;
         dir_q       <= '0;
         idx_q       <= '0;
         tries_q     <= '0;
         first_q     <= 1'b0;
         init_left_q <= 1'b0;
         lfsr_q      <= 16'hACE1;
      end else begin
         state_q     <= state_d;
         board_q     <= board_d;
         score_q     <= score_d;
         cap_board_q <= cap_board_d;
         cap_score_q <= cap_score_d;
         dir_q       <= dir_d;
         idx_q       <= idx_d;
         tries_q     <= tries_d;
         first_q     <= first_d;
         init_left_q <= init_left_d;
         lfsr_q      <= lfsr_d;
      end
   end
endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: dir_valid  in  1  move-request strobe; direction  in  4  one-hot: 0001 up, 0010 down, 0100 left, 1000 right.
REQ-003 SHALL have datapath ports: mm_direction  out  4  direction to merge datapath (0000 = idle); mm_board_in  out  [3:0][3:0]x12  board to datapath.
REQ-004 SHALL have datapath ports: mm_board_out  in  [3:0][3:0]x12  merged board; mm_score_update  in  20  points from merge; mm_done  in  1  datapath result valid.
REQ-005 SHALL have status ports: board  out  [3:0][3:0]x12  committed board; score  out  20  running score; busy  out  1  request not accepted; moved  out  1  one-cycle pulse on an effective move; game_won  out  1; game_over  out  1.
REQ-006 Tile values SHALL be literal (12'h002, 12'h004, ... 12'h800); 12'h000 = empty.

Function
REQ-007 FSM states SHALL be INIT, IDLE, MOVE, COMMIT, SPAWN, CHECK, WON, OVER.
REQ-008 INIT SHALL clear the board and score, spawn two tiles (each via SPAWN rules), then go to IDLE.
REQ-009 In IDLE, busy=0; a dir_valid with exactly one direction bit set SHALL latch direction and enter MOVE next cycle; non-one-hot or 0000 SHALL be ignored.
REQ-010 dir_valid outside IDLE SHALL be ignored, with no queuing.
REQ-011 In MOVE, mm_direction SHALL equal the latched direction and mm_board_in the committed board; in all other states mm_direction = 0000.
REQ-012 MOVE SHALL wait for mm_done=1; in that cycle, mm_board_out and mm_score_update SHALL be captured and the FSM SHALL enter COMMIT.
REQ-013 In COMMIT, if the captured board equals the committed board, the FSM SHALL return to IDLE with board, score and moved unchanged.
REQ-014 Otherwise, COMMIT SHALL write the board, add the score with saturation at 20'hFFFFF, pulse moved for one cycle, and enter SPAWN.
REQ-015 A 16-bit LFSR (x^16+x^14+x^13+x^11+1, nonzero seed 16'hACE1) SHALL advance every cycle.
REQ-016 SPAWN SHALL take LFSR[3:0] as the start cell index (row = idx[3:2], col = idx[1:0]).
REQ-017 If the start cell is occupied, SPAWN SHALL increment the index mod 16 once per cycle until an empty cell is found; SPAWN SHALL last at most 16 cycles.
REQ-018 SPAWN SHALL write 12'h002 to the empty cell, or 12'h004 per REQ-025, then enter CHECK.
REQ-019 CHECK (one cycle) SHALL enter WON if any tile == 12'h800.
REQ-020 Otherwise, CHECK SHALL enter OVER if there is no empty cell and no horizontally or vertically adjacent equal pair.
REQ-021 Otherwise, CHECK SHALL enter IDLE.
REQ-022 WON and OVER SHALL be terminal until rst; game_won and game_over SHALL be held high there; busy=1 in every state except IDLE.

Reset
REQ-023 On rst=1 at a clock edge, all of the following SHALL happen regardless of state, including mid-MOVE or mid-SPAWN: board = all 12'h000, score = 0, moved = 0, game_won = 0, game_over = 0, busy = 1, mm_direction = 0000, LFSR = 16'hACE1; the FSM SHALL enter INIT.
REQ-024 The first IDLE cycle SHALL occur at most 34 cycles after rst is released.

Configuration
REQ-025 With macro SPAWN_FOUR_EN defined, SPAWN SHALL write 12'h004 when LFSR[7:4] == 4'h0 and 12'h002 otherwise.
REQ-026 Without SPAWN_FOUR_EN, SPAWN SHALL always write 12'h002 and LFSR[7:4] SHALL be unused.

Verification
REQ-027 Reset then idle: two nonzero cells of 12'h002, score=0, busy=0, game_won=0, game_over=0.
REQ-028 Force board row0 = 002 002 004 004; datapath model returns row0 = 004 008 000 000 and mm_score_update=12 for direction 0100 -> score=12, moved pulses once, exactly one new tile appears, FSM returns to IDLE.
REQ-029 Datapath model returns an unchanged board -> no moved pulse, score unchanged, no spawn, busy low again within 2 cycles of mm_done.
REQ-030 Invalid direction 0011, and a second dir_valid during MOVE -> both ignored; mm_direction never shows 0011.
REQ-031 Full board with no adjacent equal pairs after spawn -> game_over=1 held; a merge producing 12'h800 -> game_won=1; subsequent dir_valid ignored until rst.
REQ-032 Assert rst during a 10-cycle mm_done stall in MOVE -> next cycle state INIT, mm_direction=0000, score=0; repeat with and without SPAWN_FOUR_EN, checking that 004 tiles appear only when the macro is defined.
